rgb_pl9823_rx: RTL and testbench
================================

# rgb_pl9823_rx

One-wire PL9823 stream receiver. It samples the serial LED data line, classifies each bit by its high-pulse width, and assembles 24-bit pixels. It reports each pixel with an index within the frame and detects the ≥50 µs low latch gap that ends a frame. It sits on the loopback/monitor side of the LED drivers and decodes what the transmit blocks put on the wire (50 MHz, 1720 ns bit period, 360 ns "0" high time).

## Interface
Parameters:
- T_MIN_HIGH, 5: minimum legal high width in cycles; shorter pulses are glitches.
- T_THRESH, 43: high width ≥ T_THRESH decodes as '1', below it as '0'.
- T_MAX_HIGH, 80: maximum legal high width in cycles.
- T_RESET, 2500: consecutive low cycles (50 µs) that constitute the latch/reset gap.
- CW, 12: counter width. It must satisfy 2^CW > T_RESET.

Ports:
- CLK, in, 1: 50 MHz clock. All logic uses the rising edge.
- RST_N, in, 1: asynchronous, active-low reset.
- DIN, in, 1: asynchronous one-wire data line.
- PIXEL, out, 24: last decoded pixel. The first received bit lands in PIXEL[23], so wire order is R, G, B, each MSB first.
- PIXEL_VALID, out, 1: one-cycle strobe. PIXEL and PIXEL_IDX are valid while it is high.
- PIXEL_IDX, out, 8: index of the pixel within the current frame, starting at 0. It wraps from 255 to 0.
- FRAME_END, out, 1: one-cycle strobe when the latch gap is detected.
- ERR, out, 1: one-cycle strobe on a protocol error.

## Operation
- DIN passes through a 2-FF synchronizer. All decoding uses the synchronized signal `s`. The measured widths equal the DIN widths because both edges see the same delay.
- Reset values:
  - All outputs 0.
  - State SYNC.
  - Counter 0, bit count 0, shift register 0.
- State SYNC:
  - Counts consecutive low cycles of `s`. A high sample clears the count.
  - When the count reaches T_RESET, go to IDLE. No FRAME_END is issued.
  - This prevents joining a stream mid-frame after reset.
- State IDLE: on a rising edge of `s`, clear the counter and go to HIGH.
- State HIGH:
  - Counts high cycles. Width W equals the number of cycles `s` was high.
  - On a falling edge with W < T_MIN_HIGH or W > T_MAX_HIGH: pulse ERR, discard the partial pixel, clear the bit count, go to SYNC.
  - If the count exceeds T_MAX_HIGH while `s` is still high, take the same error path immediately.
  - Otherwise shift in bit (W ≥ T_THRESH) and increment the bit count.
  - On the 24th bit: update PIXEL, pulse PIXEL_VALID, then increment PIXEL_IDX on the cycle after the strobe.
  - In all non-error cases, clear the counter and go to LOW.
- State LOW:
  - Counts low cycles.
  - On a rising edge, clear the counter and go to HIGH. The low width has no minimum.
  - When the count reaches T_RESET: pulse FRAME_END, reset PIXEL_IDX to 0, go to IDLE.
  - If the bit count is nonzero at that point: also pulse ERR in the same cycle and discard the partial bits.
- Arithmetic rules:
  - The counter saturates at 2^CW−1.
  - The bit count is 5 bits and runs 0–23. It returns to 0 after the 24th bit.
- Simultaneous events: ERR and FRAME_END may coincide. PIXEL_VALID never coincides with either.
- Asserting RST_N mid-frame aborts immediately. No strobes are issued. The block re-enters SYNC.

## Timing
- Bit latency: a DIN falling edge at clock edge t is seen by the HIGH state at t+2. PIXEL and PIXEL_VALID update at t+3.
- FRAME_END is asserted T_RESET+2 cycles after the last DIN falling edge, give or take 1 cycle from synchronization.
- PIXEL holds its value between strobes.
- Back-to-back pixels: there is no gap requirement. At the nominal 86-cycle bit period, PIXEL_VALID strobes are 2064 cycles apart.

## Structure
- Shared package `pl9823_pkg` holds:
  - the timing constants (bit period 86, T0H 18, T1H 68, reset gap 3000 on transmit; the receive defaults above);
  - the receiver state enum {SYNC, IDLE, HIGH, LOW}.
- Sub-module `pl9823_din_sync` is the 2-FF synchronizer. It outputs `s`, `rise`, and `fall` single-cycle strobes.
- Everything else lives in one FSM with a counter, a 24-bit shift register, and a bit counter.

## Test plan
- Reset, then DIN low for 3000 cycles, then 72 bits each with high 18 / period 86, then 3000 low → three PIXEL_VALID strobes with PIXEL=0x000000 and IDX 0, 1, 2, then one FRAME_END and no ERR.
- Same framing with pixel bits for 0xFF0000, 0x00FF00, 0xA5C3 3C (0xA5C33C), using high 68 for '1' → PIXEL values match exactly, each strobe 3 cycles after the 24th falling edge.
- Threshold boundaries:
  - high widths 42 / 43 decode as 0 / 1;
  - width 5 is accepted and width 4 gives ERR;
  - width 80 is accepted and 81 gives ERR then resync.
- 10 valid bits, then 3000 low → ERR and FRAME_END in the same cycle, no PIXEL_VALID; the next frame decodes from IDX 0.
- RST_N pulsed low mid-pixel, stream continues → no strobes until a 2500-cycle low gap is seen; the following frame decodes correctly.
- DIN toggling before the first 2500-cycle low after reset → no PIXEL_VALID, FRAME_END, or ERR.

Source files
------------

// File: rtl/pl9823_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pl9823_pkg
// Description : PL9823 one-wire timing constants and receiver state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pl9823_pkg;

    // Transmit-side timing at 50 MHz, in clock cycles
    localparam int c_tx_bit_period = 86;
    localparam int c_tx_t0h        = 18;
    localparam int c_tx_t1h        = 68;
    localparam int c_tx_reset_gap  = 3000;

    // Receive-side defaults
    localparam int c_rx_t_min_high = 5;
    localparam int c_rx_t_thresh   = 43;
    localparam int c_rx_t_max_high = 80;
    localparam int c_rx_t_reset    = 2500;
    localparam int c_rx_cw         = 12;

    localparam int c_pixel_w       = 24;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/pl9823_din_sync.sv
`default_nettype none
// ============================================================================
// Module      : pl9823_din_sync
// Description : 2-FF synchronizer for the one-wire line with edge strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module pl9823_din_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_s,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_s    = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/rgb_pl9823_rx.sv
`default_nettype none
// ============================================================================
// Module      : rgb_pl9823_rx
// Description : PL9823 one-wire receiver: pulse-width bit decode, 24-bit pixel
//               assembly, frame index and latch-gap detection.
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_pl9823_rx
    import pl9823_pkg::*;
#(
    parameter int T_MIN_HIGH = c_rx_t_min_high,
    parameter int T_THRESH   = c_rx_t_thresh,
    parameter int T_MAX_HIGH = c_rx_t_max_high,
    parameter int T_RESET    = c_rx_t_reset,
    parameter int CW         = c_rx_cw
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 DIN,
    output logic [c_pixel_w-1:0] PIXEL,
    output logic                 PIXEL_VALID,
    output logic [7:0]           PIXEL_IDX,
    output logic                 FRAME_END,
    output logic                 ERR
);

    localparam logic [CW-1:0] c_min      = CW'(T_MIN_HIGH);
    localparam logic [CW-1:0] c_thresh   = CW'(T_THRESH);
    localparam logic [CW-1:0] c_max      = CW'(T_MAX_HIGH);
    localparam logic [CW-1:0] c_reset_m1 = CW'(T_RESET - 1);
    localparam logic [CW-1:0] c_one      = CW'(1);
    localparam logic [CW-1:0] c_sat      = {CW{1'b1}};

    logic w_s;
    logic w_rise;
    logic w_fall;

    pl9823_din_sync u_din_sync (
        .clk    (CLK),
        .rst_n  (RST_N),
        .i_din  (DIN),
        .o_s    (w_s),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    rx_state_t              r_state;
    logic [CW-1:0]          r_cnt;
    logic [4:0]             r_bits;
    logic [c_pixel_w-1:0]   r_shift;
    logic [c_pixel_w-1:0]   r_pixel;
    logic [7:0]             r_idx;
    logic                   r_valid;
    logic                   r_frame_end;
    logic                   r_err;

    logic [CW-1:0]          w_cnt_inc;
    logic                   w_bit;
    logic                   w_err_now;

    assign w_cnt_inc = (r_cnt == c_sat) ? r_cnt : r_cnt + c_one;
    // In HIGH, r_cnt is the high width so far; on the fall cycle it is the final width.
    assign w_bit     = (r_cnt >= c_thresh);
    assign w_err_now = w_fall ? ((r_cnt < c_min) || (r_cnt > c_max))
                              : (w_cnt_inc > c_max);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= SYNC;
            r_cnt       <= '0;
            r_bits      <= '0;
            r_shift     <= '0;
            r_pixel     <= '0;
            r_idx       <= '0;
            r_valid     <= 1'b0;
            r_frame_end <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_end <= 1'b0;
            r_err       <= 1'b0;
            if (r_valid) begin
                r_idx <= r_idx + 8'd1;
            end

            case (r_state)
                SYNC: begin
                    if (w_s) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_reset_m1) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                IDLE: begin
                    // The rise cycle is already the first high cycle
                    if (w_rise) begin
                        r_cnt   <= c_one;
                        r_state <= HIGH;
                    end
                end

                HIGH: begin
                    if (w_err_now) begin
                        r_err   <= 1'b1;
                        r_bits  <= '0;
                        r_shift <= '0;
                        r_cnt   <= '0;
                        r_state <= SYNC;
                    end else if (w_fall) begin
                        r_shift <= {r_shift[c_pixel_w-2:0], w_bit};
                        if (r_bits == 5'd23) begin
                            r_bits  <= '0;
                            r_pixel <= {r_shift[c_pixel_w-2:0], w_bit};
                            r_valid <= 1'b1;
                        end else begin
                            r_bits <= r_bits + 5'd1;
                        end
                        r_cnt   <= c_one;
                        r_state <= LOW;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                LOW: begin
                    if (w_rise) begin
                        r_cnt   <= c_one;
                        r_state <= HIGH;
                    end else if (r_cnt == c_reset_m1) begin
                        r_frame_end <= 1'b1;
                        r_err       <= (r_bits != 5'd0);
                        r_idx       <= '0;
                        r_bits      <= '0;
                        r_shift     <= '0;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                default: begin
                    r_state <= SYNC;
                end
            endcase
        end
    end

    assign PIXEL       = r_pixel;
    assign PIXEL_VALID = r_valid;
    assign PIXEL_IDX   = r_idx;
    assign FRAME_END   = r_frame_end;
    assign ERR         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rgb_pl9823_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb_pl9823_rx
// Description : Self-checking bench for rgb_pl9823_rx against a pulse-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_pl9823_rx;

    localparam int T_MIN    = 5;
    localparam int T_THRESH = 43;
    localparam int T_MAX    = 80;
    localparam int T_RESET  = 2500;
    localparam int GAP      = 3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din;
    logic [23:0] pixel;
    logic        pixel_valid;
    logic [7:0]  pixel_idx;
    logic        frame_end;
    logic        err;

    rgb_pl9823_rx #(
        .T_MIN_HIGH (T_MIN),
        .T_THRESH   (T_THRESH),
        .T_MAX_HIGH (T_MAX),
        .T_RESET    (T_RESET),
        .CW         (12)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .DIN         (din),
        .PIXEL       (pixel),
        .PIXEL_VALID (pixel_valid),
        .PIXEL_IDX   (pixel_idx),
        .FRAME_END   (frame_end),
        .ERR         (err)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [23:0] got_pd[$];
    int          got_pi[$];
    int          got_pc[$];
    int          got_fe[$];
    int          got_err[$];
    int          got_both    = 0;
    int          got_collide = 0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (pixel_valid === 1'b1) begin
                got_pd.push_back(pixel);
                got_pi.push_back(int'(pixel_idx));
                got_pc.push_back(cyc);
            end
            if (frame_end === 1'b1) got_fe.push_back(cyc);
            if (err === 1'b1) got_err.push_back(cyc);
            if (err === 1'b1 && frame_end === 1'b1) got_both++;
            if (pixel_valid === 1'b1 && (err === 1'b1 || frame_end === 1'b1)) got_collide++;
        end
    end

    initial begin
        #(20 * 150000);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    // Stimulus: per pulse high width, following low width, and recorded edge cycles
    int pw[$];
    int pl[$];
    int pr[$];
    int pf[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp, input int tol);
        n_assert++;
        assert ((obs >= exp - tol) && (obs <= exp + tol))
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic drive(input logic v, input int n, output int t);
        #1 din = v;
        t = cyc;
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        din = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst PIXEL", 32'(pixel), 32'h0);
        check_eq("rst PIXEL_VALID", 32'(pixel_valid), 32'h0);
        check_eq("rst PIXEL_IDX", 32'(pixel_idx), 32'h0);
        check_eq("rst FRAME_END", 32'(frame_end), 32'h0);
        check_eq("rst ERR", 32'(err), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        got_pd.delete(); got_pi.delete(); got_pc.delete();
        got_fe.delete(); got_err.delete();
        got_both = 0; got_collide = 0;
        @(posedge clk);
    endtask

    task automatic add_pulse(input int w, input int l);
        pw.push_back(w);
        pl.push_back(l);
    endtask

    task automatic add_bit(input logic b, input bit nominal);
        int w;
        if (nominal) begin
            w = b ? 68 : 18;
            add_pulse(w, 86 - w);
        end else begin
            w = b ? int'($urandom_range(80, 43)) : int'($urandom_range(42, 5));
            add_pulse(w, int'($urandom_range(40, 1)));
        end
    endtask

    task automatic add_pixel(input logic [23:0] d, input bit nominal);
        for (int b = 23; b >= 0; b--) add_bit(d[b], nominal);
    endtask

    task automatic set_gap();
        pl[pl.size() - 1] = GAP;
    endtask

    task automatic play(input int l0);
        int t;
        drive(1'b0, l0, t);
        for (int i = 0; i < pw.size(); i++) begin
            drive(1'b1, pw[i], t);
            pr.push_back(t);
            drive(1'b0, pl[i], t);
            pf.push_back(t);
        end
    endtask

    // Pulse-level reference: decode rules applied per pulse, events timed from edges
    task automatic check_run(input string tag, input int l0);
        int          mode;   // 0 waiting for first gap, 1 between frames, 2 inside a frame
        int          bits;
        int          idx;
        int          e_both;
        int          n;
        logic [23:0] acc;
        logic [23:0] e_pd[$];
        int          e_pi[$];
        int          e_pc[$];
        int          e_fe[$];
        int          e_err[$];
        int          e_tol[$];
        logic [23:0] last;

        mode = (l0 >= T_RESET) ? 1 : 0;
        bits = 0; idx = 0; e_both = 0; acc = '0;
        for (int i = 0; i < pw.size(); i++) begin
            if (mode != 0) begin
                if (pw[i] < T_MIN || pw[i] > T_MAX) begin
                    if (pw[i] > T_MAX) begin
                        e_err.push_back(pr[i] + T_MAX + 3); e_tol.push_back(1);
                    end else begin
                        e_err.push_back(pf[i] + 3); e_tol.push_back(0);
                    end
                    mode = 0; bits = 0;
                end else begin
                    acc = {acc[22:0], (pw[i] >= T_THRESH)};
                    bits++;
                    mode = 2;
                    if (bits == 24) begin
                        e_pd.push_back(acc); e_pi.push_back(idx); e_pc.push_back(pf[i] + 3);
                        idx = (idx + 1) % 256;
                        bits = 0;
                    end
                end
            end
            if (pl[i] >= T_RESET) begin
                if (mode == 2) begin
                    e_fe.push_back(pf[i] + T_RESET + 2);
                    if (bits != 0) begin
                        e_err.push_back(pf[i] + T_RESET + 2); e_tol.push_back(1);
                        e_both++;
                    end
                    idx = 0;
                end
                mode = 1; bits = 0;
            end
        end

        check_near({tag, " pixel count"}, got_pd.size(), e_pd.size(), 0);
        n = (got_pd.size() < e_pd.size()) ? got_pd.size() : e_pd.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s pixel[%0d] data", tag, i), 32'(got_pd[i]), 32'(e_pd[i]));
            check_near($sformatf("%s pixel[%0d] idx", tag, i), got_pi[i], e_pi[i], 0);
            check_near($sformatf("%s pixel[%0d] cycle", tag, i), got_pc[i], e_pc[i], 0);
        end
        check_near({tag, " frame_end count"}, got_fe.size(), e_fe.size(), 0);
        n = (got_fe.size() < e_fe.size()) ? got_fe.size() : e_fe.size();
        for (int i = 0; i < n; i++)
            check_near($sformatf("%s frame_end[%0d] cycle", tag, i), got_fe[i], e_fe[i], 1);
        check_near({tag, " err count"}, got_err.size(), e_err.size(), 0);
        n = (got_err.size() < e_err.size()) ? got_err.size() : e_err.size();
        for (int i = 0; i < n; i++)
            check_near($sformatf("%s err[%0d] cycle", tag, i), got_err[i], e_err[i], e_tol[i]);
        check_near({tag, " err with frame_end"}, got_both, e_both, 0);
        check_near({tag, " valid overlaps err/frame_end"}, got_collide, 0, 0);
        last = (e_pd.size() > 0) ? e_pd[e_pd.size() - 1] : 24'h0;
        check_eq({tag, " PIXEL held"}, 32'(pixel), 32'(last));

        pw.delete(); pl.delete(); pr.delete(); pf.delete();
    endtask

    initial begin
        logic [23:0] rd;
        rst_n = 1'b0;
        din   = 1'b0;

        // Three all-zero pixels at nominal timing
        do_reset();
        for (int i = 0; i < 72; i++) add_pulse(18, 68);
        set_gap();
        play(GAP);
        check_run("zeros", GAP);

        // Nominal colours
        do_reset();
        add_pixel(24'hFF0000, 1'b1);
        add_pixel(24'h00FF00, 1'b1);
        add_pixel(24'hA5C33C, 1'b1);
        set_gap();
        play(GAP);
        check_run("colours", GAP);

        // Width boundaries, errors and resync, partial frame
        do_reset();
        for (int i = 0; i < 6; i++) begin
            add_pulse(42, int'($urandom_range(40, 1)));
            add_pulse(43, int'($urandom_range(40, 1)));
            add_pulse(5,  int'($urandom_range(40, 1)));
            add_pulse(80, int'($urandom_range(40, 1)));
        end
        set_gap();
        add_pulse(4, GAP);
        rd = 24'($urandom); add_pixel(rd, 1'b0);
        set_gap();
        add_pulse(81, GAP);
        rd = 24'($urandom); add_pixel(rd, 1'b0);
        rd = 24'($urandom); add_pixel(rd, 1'b0);
        set_gap();
        for (int i = 0; i < 10; i++) add_bit(1'($urandom_range(1, 0)), 1'b0);
        set_gap();
        rd = 24'($urandom); add_pixel(rd, 1'b0);
        set_gap();
        play(GAP);
        check_run("bounds", GAP);

        // Reset mid-pixel, then a stream that toggles before any gap
        do_reset();
        for (int i = 0; i < 10; i++) add_bit(1'($urandom_range(1, 0)), 1'b1);
        pl[pl.size() - 1] = 50;
        play(GAP);
        check_run("pre-reset", GAP);
        do_reset();
        for (int i = 0; i < 40; i++)
            add_pulse(int'($urandom_range(100, 1)), int'($urandom_range(40, 1)));
        set_gap();
        rd = 24'($urandom); add_pixel(rd, 1'b0);
        rd = 24'($urandom); add_pixel(rd, 1'b0);
        set_gap();
        play(5);
        check_run("post-reset", 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
